// File: rtl/div_seq_sgn.sv
// div_seq_sgn: multi-cycle signed/unsigned integer divider.
// Restoring shift-subtract on operand magnitudes, STEP quotient bits per
// clock, followed by one sign-fix cycle that writes the result registers.
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   asynchronous active-high reset
//   START in   request, accepted when BUSY=0
//   SGN   in   1 = two's-complement signed, 0 = unsigned (sampled with START)
//   A     in   dividend (sampled with START)
//   B     in   divisor  (sampled with START)
//   BUSY  out  operation in progress
//   DONE  out  Q/R/DZ hold the result of the last accepted operation
//   Q     out  quotient
//   R     out  remainder
//   DZ    out  last result was a divide by zero
module div_seq_sgn #(
  parameter int unsigned LEN  = 16,
  parameter int unsigned STEP = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           SGN,
  input  logic [LEN-1:0] A,
  input  logic [LEN-1:0] B,
  output logic           BUSY,
  output logic           DONE,
  output logic [LEN-1:0] Q,
  output logic [LEN-1:0] R,
  output logic           DZ
);

  localparam int unsigned N  = LEN / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [LEN-1:0] a_org;   // original dividend bits, returned as R on divide by zero
  logic           b_zero;
  logic           neg_q;
  logic           neg_r;
  logic [LEN-1:0] quo;     // dividend magnitude shifting out, quotient bits shifting in
  logic [LEN-1:0] dvs;     // divisor magnitude
  logic [LEN:0]   rem;     // partial remainder, one bit wider than the operands

  logic [LEN-1:0] a_mag;
  logic [LEN-1:0] b_mag;
  logic [LEN:0]   rem_n;
  logic [LEN-1:0] quo_n;

  // Operand magnitudes at acceptance
  always_comb begin
    a_mag = A;
    b_mag = B;
    if (SGN && A[LEN-1]) a_mag = LEN'(~A + LEN'(1));
    if (SGN && B[LEN-1]) b_mag = LEN'(~B + LEN'(1));
  end

  // STEP restoring shift-subtract steps per cycle
  always_comb begin
    rem_n = rem;
    quo_n = quo;
    for (int unsigned i = 0; i < STEP; i++) begin
      rem_n = {rem_n[LEN-1:0], quo_n[LEN-1]};
      quo_n = {quo_n[LEN-2:0], 1'b0};
      if (rem_n >= {1'b0, dvs}) begin
        rem_n    = rem_n - {1'b0, dvs};
        quo_n[0] = 1'b1;
      end
    end
  end

  // Control FSM, datapath and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      a_org  <= '0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      Q      <= '0;
      R      <= '0;
      DZ     <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (START) begin
            a_org  <= A;
            b_zero <= (B == '0);
            neg_q  <= SGN & (A[LEN-1] ^ B[LEN-1]);
            neg_r  <= SGN & A[LEN-1];
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            cnt    <= CW'(N - 1);
            BUSY   <= 1'b1;
            DONE   <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        FIX: begin
          if (b_zero) begin
            Q  <= '1;
            R  <= a_org;
            DZ <= 1'b1;
          end else begin
            Q  <= neg_q ? LEN'(~quo + LEN'(1)) : quo;
            R  <= neg_r ? LEN'(~rem[LEN-1:0] + LEN'(1)) : rem[LEN-1:0];
            DZ <= 1'b0;
          end
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          state <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_sgn.sv
// tb_div_seq_sgn: directed-vector bench for div_seq_sgn.
// One instance with STEP=1 for the directed table and corner sequences,
// one with STEP=4 for a modelled sweep.
module tb_div_seq_sgn;

  logic        CLK = 1'b0;
  logic        RST;

  logic        st1, sg1, busy1, done1, dz1;
  logic [15:0] a1, b1, q1, r1;
  logic        st4, sg4, busy4, done4, dz4;
  logic [15:0] a4, b4, q4, r4;

  int checks = 0;
  int errors = 0;

  div_seq_sgn #(.LEN(16), .STEP(1)) d1 (
    .CLK(CLK), .RST(RST), .START(st1), .SGN(sg1), .A(a1), .B(b1),
    .BUSY(busy1), .DONE(done1), .Q(q1), .R(r1), .DZ(dz1)
  );

  div_seq_sgn #(.LEN(16), .STEP(4)) d4 (
    .CLK(CLK), .RST(RST), .START(st4), .SGN(sg4), .A(a4), .B(b4),
    .BUSY(busy4), .DONE(done4), .Q(q4), .R(r4), .DZ(dz4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? busy1 : busy4;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 1) ? done1 : done4;
  endfunction

  // Behavioural reference: {dz, q, r}
  function automatic logic [32:0] model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    int sa, sb, qq, rr;
    if (b == 16'd0) return {1'b1, 16'hFFFF, a};
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'({16'd0, a});
      sb = int'({16'd0, b});
    end
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, qq[15:0], rr[15:0]};
  endfunction

  // Issue one operation; entered and left at posedge+1. poke>0 pulses START
  // with foreign operands during that RUN cycle.
  task automatic do_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                       input logic sgn, input int poke, output int lat);
    if (sel == 1) begin a1 = a; b1 = b; sg1 = sgn; st1 = 1'b1; end
    else          begin a4 = a; b4 = b; sg4 = sgn; st4 = 1'b1; end
    @(posedge CLK); #1;
    chk("accept_busy", 32'(busy_of(sel)), 32'd1);
    chk("accept_done", 32'(done_of(sel)), 32'd0);
    st1 = 1'b0; st4 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge CLK); #1;
      if (done_of(sel)) begin
        lat = k;
        break;
      end
      if (busy_of(sel) !== 1'b1) begin
        chk("busy_during_run", 32'(busy_of(sel)), 32'd1);
      end
      if (poke > 0 && k == poke) begin
        if (sel == 1) begin a1 = 16'd5; b1 = 16'd5; sg1 = 1'b0; st1 = 1'b1; end
        else          begin a4 = 16'd5; b4 = 16'd5; sg4 = 1'b0; st4 = 1'b1; end
      end else begin
        st1 = 1'b0; st4 = 1'b0;
      end
    end
    st1 = 1'b0; st4 = 1'b0;
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    logic [32:0] exp;

    vecs[0] = '{16'd100,  16'd7,    1'b0, 16'h000E, 16'h0002, 1'b0};
    vecs[1] = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0};
    vecs[2] = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0};
    vecs[4] = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1};
    vecs[5] = '{16'hFF00, 16'h0000, 1'b1, 16'hFFFF, 16'hFF00, 1'b1};
    vecs[6] = '{16'd1000, 16'd3,    1'b0, 16'd333,  16'd1,    1'b0};

    RST = 1'b1;
    st1 = 1'b0; sg1 = 1'b0; a1 = '0; b1 = '0;
    st4 = 1'b0; sg4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_q",    32'(q1),    32'd0);
    chk("rst_r",    32'(r1),    32'd0);
    chk("rst_dz",   32'(dz1),   32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed table, issued back to back on the cycle DONE is first seen
    foreach (vecs[i]) begin
      do_op(1, vecs[i].a, vecs[i].b, vecs[i].sgn, 0, lat);
      chk("tbl_latency", 32'(lat), 32'd17);
      chk("tbl_q",  32'(q1),    32'(vecs[i].q));
      chk("tbl_r",  32'(r1),    32'(vecs[i].r));
      chk("tbl_dz", 32'(dz1),   32'(vecs[i].dz));
      chk("tbl_busy_after", 32'(busy1), 32'd0);
    end

    // START with other operands mid-run is ignored
    do_op(1, 16'd1000, 16'd7, 1'b0, 5, lat);
    chk("poke_latency", 32'(lat), 32'd17);
    chk("poke_q", 32'(q1), 32'd142);
    chk("poke_r", 32'(r1), 32'd6);

    // Result holds while idle
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_done", 32'(done1), 32'd1);
    chk("hold_q",    32'(q1),    32'd142);

    // Reset at cycle 8 of a run clears outputs without a clock
    a1 = 16'd50; b1 = 16'd3; sg1 = 1'b0; st1 = 1'b1;
    @(posedge CLK); #1;
    st1 = 1'b0;
    repeat (7) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_dz",   32'(dz1),   32'd0);
    chk("abort_q",    32'(q1),    32'd0);
    chk("abort_r",    32'(r1),    32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    do_op(1, 16'd200, 16'd9, 1'b0, 0, lat);
    chk("post_rst_latency", 32'(lat), 32'd17);
    chk("post_rst_q", 32'(q1), 32'd22);
    chk("post_rst_r", 32'(r1), 32'd2);
    chk("post_rst_dz", 32'(dz1), 32'd0);

    // STEP=4 sweep against the reference model
    for (int i = 0; i < 100; i++) begin
      logic [15:0] sa, sb;
      logic        ss;
      sa = 16'(i * 193);
      sb = 16'(i * 1543);
      ss = 1'(i % 2);
      exp = model(sa, sb, ss);
      do_op(4, sa, sb, ss, 0, lat);
      chk("sweep_latency", 32'(lat), 32'd5);
      chk("sweep_q",  32'(q4),  32'(exp[31:16]));
      chk("sweep_r",  32'(r4),  32'(exp[15:0]));
      chk("sweep_dz", 32'(dz4), 32'(exp[32]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
